// File: rtl/mcfsm_pkg.sv
// Shared types and encodings for the multicycle control FSM: state enum, opcode
// classes, control-word bit positions and field codes.
package mcfsm_pkg;

   localparam int OPC_W_DEF  = 6;
   localparam int CTRL_W_DEF = 16;
   localparam int CNT_W_DEF  = 32;

   typedef enum logic [3:0] {
      S_FETCH   = 4'd0,
      S_DECODE  = 4'd1,
      S_EXEC_R  = 4'd2,
      S_EXEC_I  = 4'd3,
      S_ALU_WB  = 4'd4,
      S_MEM_ADR = 4'd5,
      S_MEM_RD  = 4'd6,
      S_MEM_WB  = 4'd7,
      S_MEM_WR  = 4'd8,
      S_BRANCH  = 4'd9,
      S_JUMP    = 4'd10,
      S_HALT    = 4'd11
   } state_t;

   localparam logic [5:0] OP_LW   = 6'b100000;
   localparam logic [5:0] OP_SW   = 6'b100001;
   localparam logic [5:0] OP_BNE  = 6'b110000;
   localparam logic [5:0] OP_J    = 6'b110001;
   localparam logic [5:0] OP_HALT = 6'b111111;

   // ctrl_word bit positions; multi-bit fields give their LSB
   localparam int B_PCWC  = 15;
   localparam int B_PCW   = 14;
   localparam int B_IORD  = 13;
   localparam int B_MEMR  = 12;
   localparam int B_MEMW  = 11;
   localparam int B_M2R   = 10;
   localparam int B_IRW   = 9;
   localparam int B_PCSRC = 7;
   localparam int B_ALUOP = 5;
   localparam int B_SRCB  = 3;
   localparam int B_SRCA  = 2;
   localparam int B_REGW  = 1;
   localparam int B_REGD  = 0;

   localparam logic [1:0] SRCB_B    = 2'b00;
   localparam logic [1:0] SRCB_ONE  = 2'b01;
   localparam logic [1:0] SRCB_IMM  = 2'b10;
   localparam logic [1:0] SRCB_RD2  = 2'b11;
   localparam logic [1:0] PCS_ALU    = 2'b00;
   localparam logic [1:0] PCS_ALUOUT = 2'b01;
   localparam logic [1:0] PCS_JUMP   = 2'b10;
   localparam logic [1:0] ALUOP_ADD  = 2'b00;
   localparam logic [1:0] ALUOP_SUB  = 2'b01;
   localparam logic [1:0] ALUOP_FUNC = 2'b10;

   // Enables that must not fire again while the FSM is held
   localparam logic [CTRL_W_DEF-1:0] SIDE_FX_MASK =
      CTRL_W_DEF'((1 << B_PCWC) | (1 << B_PCW) | (1 << B_IRW) | (1 << B_REGW) | (1 << B_MEMW));

endpackage

// File: rtl/mcfsm_ctrl_decode.sv
// Combinational state -> ctrl_word table; every field not named for a state stays 0.
module mcfsm_ctrl_decode
   import mcfsm_pkg::*;
(
   input  state_t                  state,
   output logic [CTRL_W_DEF-1:0]   ctrl
);

   always_comb begin
      ctrl = '0;
      case (state)
         S_FETCH: begin
            ctrl[B_IRW]           = 1'b1;
            ctrl[B_PCW]           = 1'b1;
            ctrl[B_MEMR]          = 1'b1;
            ctrl[B_SRCB +: 2]     = SRCB_ONE;
            ctrl[B_ALUOP +: 2]    = ALUOP_ADD;
            ctrl[B_PCSRC +: 2]    = PCS_ALU;
         end
         S_DECODE: begin
            ctrl[B_SRCB +: 2]     = SRCB_IMM;
            ctrl[B_ALUOP +: 2]    = ALUOP_ADD;
         end
         S_EXEC_R: begin
            ctrl[B_SRCA]          = 1'b1;
            ctrl[B_SRCB +: 2]     = SRCB_B;
            ctrl[B_ALUOP +: 2]    = ALUOP_FUNC;
         end
         S_EXEC_I: begin
            ctrl[B_SRCA]          = 1'b1;
            ctrl[B_SRCB +: 2]     = SRCB_IMM;
            ctrl[B_ALUOP +: 2]    = ALUOP_FUNC;
         end
         S_ALU_WB: begin
            ctrl[B_REGW]          = 1'b1;
            ctrl[B_REGD]          = 1'b1;
         end
         S_MEM_ADR: begin
            ctrl[B_SRCA]          = 1'b1;
            ctrl[B_SRCB +: 2]     = SRCB_IMM;
            ctrl[B_ALUOP +: 2]    = ALUOP_ADD;
         end
         S_MEM_RD: begin
            ctrl[B_MEMR]          = 1'b1;
            ctrl[B_IORD]          = 1'b1;
         end
         S_MEM_WB: begin
            ctrl[B_REGW]          = 1'b1;
            ctrl[B_M2R]           = 1'b1;
         end
         S_MEM_WR: begin
            ctrl[B_MEMW]          = 1'b1;
            ctrl[B_IORD]          = 1'b1;
         end
         S_BRANCH: begin
            ctrl[B_PCWC]          = 1'b1;
            ctrl[B_SRCA]          = 1'b1;
            ctrl[B_SRCB +: 2]     = SRCB_B;
            ctrl[B_ALUOP +: 2]    = ALUOP_SUB;
            ctrl[B_PCSRC +: 2]    = PCS_ALUOUT;
         end
         S_JUMP: begin
            ctrl[B_PCW]           = 1'b1;
            ctrl[B_PCSRC +: 2]    = PCS_JUMP;
         end
         default: ctrl = '0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle control unit: FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK sequencing.
// Define MCFSM_PERF_CNT_EN to add the retired-instruction counter and port.
module multicycle_control_fsm
   import mcfsm_pkg::*;
#(
   parameter int OPC_W  = OPC_W_DEF,
   parameter int CTRL_W = CTRL_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              step_en,
   input  logic [OPC_W-1:0]  opcode,
   output logic [CTRL_W-1:0] ctrl_word,
   output logic [3:0]        state_o,
   output logic              halted
`ifdef MCFSM_PERF_CNT_EN
   ,
   output logic [CNT_W-1:0]  retired
`endif
);

   state_t              state, nxt;
   logic                is_store;
   logic                bad_state;
   logic [CTRL_W-1:0]   raw_ctrl;

   always_comb begin
      nxt = S_HALT;
      case (state)
         S_FETCH:   nxt = S_DECODE;
         S_DECODE: begin
            casez (opcode)
               6'b00????: nxt = S_EXEC_R;
               6'b01????: nxt = S_EXEC_I;
               OP_LW,
               OP_SW:     nxt = S_MEM_ADR;
               OP_BNE:    nxt = S_BRANCH;
               OP_J:      nxt = S_JUMP;
               default:   nxt = S_HALT;
            endcase
         end
         S_EXEC_R,
         S_EXEC_I:  nxt = S_ALU_WB;
         S_MEM_ADR: nxt = is_store ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:  nxt = S_MEM_WB;
         S_ALU_WB,
         S_MEM_WB,
         S_MEM_WR,
         S_BRANCH,
         S_JUMP:    nxt = S_FETCH;
         default:   nxt = S_HALT;
      endcase
   end

   // Corrupt encodings escape to HALT even while the FSM is held
   assign bad_state = (state > S_HALT);

   // opcode is only valid in DECODE, so the load/store choice is remembered for MEM_ADR
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_FETCH;
         halted   <= 1'b0;
         is_store <= 1'b0;
      end else if (step_en || bad_state) begin
         state  <= nxt;
         halted <= (nxt == S_HALT);
         if (state == S_DECODE)
            is_store <= (opcode == OP_SW);
      end
   end

   mcfsm_ctrl_decode u_decode (
      .state (state),
      .ctrl  (raw_ctrl)
   );

   // A held cycle keeps the datapath steering but drops every write enable
   assign ctrl_word = step_en ? raw_ctrl : (raw_ctrl & ~SIDE_FX_MASK);
   assign state_o   = state;

`ifdef MCFSM_PERF_CNT_EN
   logic retire_st;
   assign retire_st = (state == S_ALU_WB) || (state == S_MEM_WB) || (state == S_MEM_WR) ||
                      (state == S_BRANCH) || (state == S_JUMP);

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         retired <= '0;
      else if (step_en && retire_st)
         retired <= retired + 1'b1;
   end
`endif

endmodule
